// File: rtl/spi_tx_scheduler_pkg.sv
// spi_sched_pkg
//   Shared definitions for the PMD901 SPI transmit scheduler: FSM state
//   encoding, default frame width and the grant-index width helper.
package spi_sched_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        ACK_WAIT = 3'd2,
        XFER     = 3'd3,
        GAP      = 3'd4,
        ERR      = 3'd5
    } state_e;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter
//   Picks one requester per win: requester 0 always takes priority, the
//   rest are served round-robin starting at rr_ptr. The pick is purely
//   combinational; rr_ptr only advances when the scheduler accepts a win
//   by a round-robin requester.
// Ports
//   clk, rst     clock, async active-high reset (rr_ptr -> 1)
//   req_i        level request per requester
//   win_i        scheduler accepted the current pick this cycle
//   gnt_o        one-hot pick
//   gnt_idx_o    binary index of the pick
//   any_o        at least one requester is pending
module spi_rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               win_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        found     = 1'b0;
        if (req_i[0]) begin
            gnt_o[0] = 1'b1;
            found    = 1'b1;
        end else begin
            // Walk 1..NUM_REQ-1 beginning at rr_ptr, wrapping back to 1.
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = IDX_W'(1 + ((int'(rr_ptr_q) - 1 + k) % (NUM_REQ - 1)));
                if (!found && req_i[cand]) begin
                    gnt_o[cand] = 1'b1;
                    gnt_idx_o   = cand;
                    found       = 1'b1;
                end
            end
        end
    end

    assign any_o = found;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_i && (gnt_idx_o != '0)) begin
            if (gnt_idx_o == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_d = IDX_W'(1);
            end else begin
                rr_ptr_d = gnt_idx_o + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= IDX_W'(1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//   Shares one PMD901 SPI shifter between NUM_REQ frame requesters.
//   Arbitrates, latches the winning word, runs the spi_start/spi_ready
//   handshake with the shifter and enforces a minimum gap between frames.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a request while the shifter reports ready
//   START    | winner latched; spi_start raised for the next cycle
//   ACK_WAIT | spi_start high until the shifter drops spi_ready
//   XFER     | shifter busy; wait for spi_ready to return (frame done)
//   ERR      | handshake timed out; err pulse, then gap
//   GAP      | hold off for GAP_CYCLES before accepting the next request
//
// Ports
//   clk, rst      PCLK domain clock, async active-high reset
//   req_i         level request per requester, held until done/err
//   req_data_i    frame word per requester, slice i = [i*DATA_W +: DATA_W]
//   grant_o       one-hot owner of the frame in flight
//   done_o/err_o  one-cycle completion / timeout-abort pulse per requester
//   spi_start_o   start level towards the shifter (crosses a CDC)
//   spi_data_o    latched frame word
//   spi_ready_i   shifter idle flag, already synchronised; low = busy
//   busy_o        scheduler not in IDLE
module spi_tx_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int GAP_CYCLES     = 2001,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic                      spi_start_o,
    output logic [DATA_W-1:0]         spi_data_o,
    input  logic                      spi_ready_i,
    output logic                      busy_o
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 start_q, start_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 arb_win;
    logic [DATA_W-1:0]    slot [NUM_REQ];

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .win_i     (arb_win),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        start_d = start_q;
        data_d  = data_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        arb_win = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A low spi_ready here means the shifter is still busy
                // (e.g. straight after reset), so nothing is granted.
                if (arb_any && spi_ready_i) begin
                    arb_win = 1'b1;
                    grant_d = arb_gnt;
                    data_d  = slot[arb_idx];
                    state_d = START;
                end
            end
            START: begin
                // spi_start is registered so the level handed to the CDC
                // is glitch-free; it becomes visible in ACK_WAIT.
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (!spi_ready_i) begin
                    start_d = 1'b0;
                    tmo_d   = '0;
                    state_d = XFER;
                end else if (tmo_q >= TMO_LAST) begin
                    start_d = 1'b0;
                    err_d   = grant_q;
                    grant_d = '0;
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            XFER: begin
                if (spi_ready_i) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (tmo_q >= TMO_LAST) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ERR: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                start_d = 1'b0;
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign spi_start_o = start_q;
    assign spi_data_o  = data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_tx_scheduler.sv
module tb_spi_tx_scheduler;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 16;
    localparam int GAP_C   = 20;
    localparam int TMO_C   = 50;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_i = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data_i = {16'h2222, 16'h1234, 16'hA000};
    logic [NUM_REQ-1:0]        grant_o, done_o, err_o;
    logic                      spi_start_o;
    logic [DATA_W-1:0]         spi_data_o;
    logic                      spi_ready_i = 1'b1;
    logic                      busy_o;

    int tests = 0;
    int fails = 0;

    spi_tx_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .GAP_CYCLES     (GAP_C),
        .TIMEOUT_CYCLES (TMO_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_data_i  (req_data_i),
        .grant_o     (grant_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .spi_start_o (spi_start_o),
        .spi_data_o  (spi_data_o),
        .spi_ready_i (spi_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (grant_o == '0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_grant_seen"}, 32'(grant_o != '0), 32'(1));
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!spi_start_o && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 32'(spi_start_o), 32'(1));
    endtask

    // Shifter model: entered with spi_start visible (ACK_WAIT); acks after
    // ack_dly further cycles, stays busy xlen cycles, then reports done.
    task automatic ack_xfer(input int ack_dly, input int xlen, input string tag);
        repeat (ack_dly) tick();
        spi_ready_i = 1'b0;
        tick();
        check({tag, "_start_low_xfer"}, 32'(spi_start_o), 32'(0));
        repeat (xlen) tick();
        spi_ready_i = 1'b1;
        tick();
    endtask

    task automatic do_frame(input logic [2:0] exp_g, input logic [15:0] exp_d, input string tag);
        wait_grant(tag);
        check({tag, "_grant"}, 32'(grant_o), 32'(exp_g));
        check({tag, "_data"}, 32'(spi_data_o), 32'(exp_d));
        wait_start(tag);
        ack_xfer(2, 5, tag);
        check({tag, "_done"}, 32'(done_o), 32'(exp_g));
        check({tag, "_grant_drop"}, 32'(grant_o), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        tick();
        check("rst_grant", 32'(grant_o), 32'(0));
        check("rst_start", 32'(spi_start_o), 32'(0));
        check("rst_data",  32'(spi_data_o), 32'(0));
        check("rst_busy",  32'(busy_o), 32'(0));
        check("rst_done_err", 32'({done_o, err_o}), 32'(0));
        rst = 1'b0;
        tick();

        // 1: single request from requester 1
        req_i = 3'b010;
        tick();
        check("t1_grant", 32'(grant_o), 32'(3'b010));
        check("t1_data",  32'(spi_data_o), 32'(16'h1234));
        check("t1_start_in_START", 32'(spi_start_o), 32'(0));
        check("t1_busy",  32'(busy_o), 32'(1));
        tick();
        check("t1_start_ack_wait", 32'(spi_start_o), 32'(1));
        tick();
        tick();
        check("t1_start_held", 32'(spi_start_o), 32'(1));
        spi_ready_i = 1'b0;
        tick();
        check("t1_start_dropped", 32'(spi_start_o), 32'(0));
        repeat (40) tick();
        check("t1_no_early_done", 32'(done_o), 32'(0));
        check("t1_grant_xfer", 32'(grant_o), 32'(3'b010));
        spi_ready_i = 1'b1;
        tick();
        check("t1_done", 32'(done_o), 32'(3'b010));
        check("t1_grant_drop", 32'(grant_o), 32'(0));
        req_i = 3'b100;
        n = 1;
        tick();
        check("t1_done_pulse", 32'(done_o), 32'(0));
        while (!spi_start_o && n < 200) begin
            tick();
            n++;
        end
        check("t1_gap_to_start", 32'(n), 32'(GAP_C + 2));
        check("t1_next_grant", 32'(grant_o), 32'(3'b100));
        check("t1_next_data",  32'(spi_data_o), 32'(16'h2222));
        ack_xfer(1, 3, "t1b");
        check("t1b_done", 32'(done_o), 32'(3'b100));

        // 2: round robin between 1 and 2, then requester 0 priority
        req_i = 3'b110;
        do_frame(3'b010, 16'h1234, "t2_a");
        do_frame(3'b100, 16'h2222, "t2_b");
        do_frame(3'b010, 16'h1234, "t2_c");
        do_frame(3'b100, 16'h2222, "t2_d");
        req_i = 3'b111;
        do_frame(3'b001, 16'hA000, "t2_urgent");
        req_i = 3'b110;
        do_frame(3'b010, 16'h1234, "t2_after_urgent");

        // 3: requester 0 raised mid-frame, no preemption
        req_i = 3'b100;
        wait_grant("t3");
        check("t3_grant", 32'(grant_o), 32'(3'b100));
        wait_start("t3");
        tick();
        spi_ready_i = 1'b0;
        tick();
        repeat (3) tick();
        req_i = 3'b101;
        repeat (5) tick();
        check("t3_no_preempt", 32'(grant_o), 32'(3'b100));
        spi_ready_i = 1'b1;
        tick();
        check("t3_done", 32'(done_o), 32'(3'b100));
        req_i = 3'b001;
        do_frame(3'b001, 16'hA000, "t3_urgent");
        req_i = 3'b000;

        // 4: shifter never acknowledges -> timeout
        req_i = 3'b010;
        wait_grant("t4");
        wait_start("t4");
        n = 0;
        while (err_o == '0 && n < 200) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'(TMO_C));
        check("t4_err", 32'(err_o), 32'(3'b010));
        check("t4_start", 32'(spi_start_o), 32'(0));
        check("t4_grant", 32'(grant_o), 32'(0));
        check("t4_done", 32'(done_o), 32'(0));
        req_i = 3'b000;
        tick();
        check("t4_err_pulse", 32'(err_o), 32'(0));
        check("t4_busy_gap", 32'(busy_o), 32'(1));
        n = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        check("t4_back_idle", 32'(busy_o), 32'(0));

        // 5: reset in the middle of a transfer
        req_i = 3'b110;
        wait_grant("t5");
        check("t5_grant_rr", 32'(grant_o), 32'(3'b100));
        wait_start("t5");
        tick();
        spi_ready_i = 1'b0;
        tick();
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_grant", 32'(grant_o), 32'(0));
        check("t5_rst_start", 32'(spi_start_o), 32'(0));
        check("t5_rst_busy",  32'(busy_o), 32'(0));
        check("t5_rst_data",  32'(spi_data_o), 32'(0));
        spi_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        do_frame(3'b010, 16'h1234, "t5_resume");
        req_i = 3'b000;

        // 6: shifter busy out of reset
        rst = 1'b1;
        spi_ready_i = 1'b0;
        req_i = 3'b010;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("t6_no_grant", 32'(grant_o), 32'(0));
        check("t6_idle", 32'(busy_o), 32'(0));
        spi_ready_i = 1'b1;
        tick();
        check("t6_grant", 32'(grant_o), 32'(3'b010));
        wait_start("t6");
        ack_xfer(1, 2, "t6");
        check("t6_done", 32'(done_o), 32'(3'b010));
        req_i = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
